// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary CNN layer scheduler.
package bnn_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_S1    = 4'd1,
    ST_W1    = 4'd2,
    ST_S2    = 4'd3,
    ST_W2    = 4'd4,
    ST_S3    = 4'd5,
    ST_W3    = 4'd6,
    ST_FIN   = 4'd7,
    ST_ERROR = 4'd8
  } sched_state_t;

  localparam logic [1:0] LAYER_CONV1 = 2'd0;
  localparam logic [1:0] LAYER_CONV2 = 2'd1;
  localparam logic [1:0] LAYER_FC    = 2'd2;
  localparam int         N_LAYERS    = 3;

  // First enabled layer at index >= from; FIN when none remain.
  function automatic sched_state_t first_enabled(input logic [2:0] mask, input logic [1:0] from);
    if (from == LAYER_CONV1 && mask[0]) return ST_S1;
    if (from <= LAYER_CONV2 && mask[1]) return ST_S2;
    if (from <= LAYER_FC && mask[2])    return ST_S3;
    return ST_FIN;
  endfunction

endpackage

// File: rtl/bnn_layer_scheduler_if.sv
// Host and layer-engine handshake bundle for the layer scheduler.
interface bnn_layer_scheduler_if #(parameter int CNT_W = 16);

  logic             start;
  logic             abort;
  logic [2:0]       run_mask;
  logic             done_conv1;
  logic             done_conv2;
  logic             done_fc;
  logic             begin_conv1;
  logic             begin_conv2;
  logic             begin_fc;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_layer;
  logic [CNT_W-1:0] lat_conv1;
  logic [CNT_W-1:0] lat_conv2;
  logic [CNT_W-1:0] lat_fc;

  modport master (
    input  start, abort, run_mask, done_conv1, done_conv2, done_fc,
    output begin_conv1, begin_conv2, begin_fc, busy, done, error, err_layer,
           lat_conv1, lat_conv2, lat_fc
  );

  modport slave (
    output start, abort, run_mask, done_conv1, done_conv2, done_fc,
    input  begin_conv1, begin_conv2, begin_fc, busy, done, error, err_layer,
           lat_conv1, lat_conv2, lat_fc
  );

endinterface

// File: rtl/layer_watchdog.sv
// Saturating wait-cycle counter shared by all engine wait states.
module layer_watchdog #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYC - 1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         count <= '0;
    else if (clr)                       count <= '0;
    else if (en && (count != CNT_MAX))  count <= count + 1'b1;
  end

  // Fires in the last allowed wait cycle; the caller lets a same-cycle done win.
  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/bnn_layer_scheduler.sv
// Sequences conv1 -> conv2 -> fc engines with per-layer latency capture and a watchdog.
module bnn_layer_scheduler
  import bnn_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bnn_layer_scheduler_if.master bus
);

  sched_state_t       state, nxt;
  logic [2:0]         mask_q;
  logic [2:0]         begin_q;
  logic               done_q, busy_q, error_q;
  logic [1:0]         err_layer_q;
  logic [CNT_W-1:0]   lat_q [N_LAYERS];

  logic [1:0]         cur_layer;
  logic               in_start, in_wait, layer_done, start_ok;
  logic [2:0]         done_vec;
  logic [CNT_W-1:0]   wd_count, lat_next;
  logic               wd_expired;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    cur_layer = LAYER_CONV1;
    in_start  = 1'b0;
    in_wait   = 1'b0;
    case (state)
      ST_S1: in_start = 1'b1;
      ST_W1: in_wait  = 1'b1;
      ST_S2: begin cur_layer = LAYER_CONV2; in_start = 1'b1; end
      ST_W2: begin cur_layer = LAYER_CONV2; in_wait  = 1'b1; end
      ST_S3: begin cur_layer = LAYER_FC;    in_start = 1'b1; end
      ST_W3: begin cur_layer = LAYER_FC;    in_wait  = 1'b1; end
      default: ;
    endcase
  end

  assign done_vec   = {bus.done_fc, bus.done_conv2, bus.done_conv1};
  assign layer_done = in_wait && done_vec[cur_layer];
  assign start_ok   = (state == ST_IDLE || state == ST_ERROR) && bus.start && !bus.abort;
  // Wait cycle n sees count n-1, so the stored latency is count+1 (saturating).
  assign lat_next   = (wd_count == '1) ? wd_count : wd_count + 1'b1;

  layer_watchdog #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (in_start),
    .en      (in_wait),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_ERROR: if (bus.start) nxt = first_enabled(bus.run_mask, LAYER_CONV1);
      ST_S1:             nxt = ST_W1;
      ST_S2:             nxt = ST_W2;
      ST_S3:             nxt = ST_W3;
      ST_W1, ST_W2, ST_W3: begin
        if (layer_done)      nxt = first_enabled(mask_q, cur_layer + 2'd1);
        else if (wd_expired) nxt = ST_ERROR;
      end
      ST_FIN:            nxt = ST_IDLE;
      default:           nxt = ST_IDLE;
    endcase
    if (bus.abort) nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      begin_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
      // NOTE: the latency array is a handful of host-visible registers, so it is reset like any other output.
      for (int i = 0; i < N_LAYERS; i++) lat_q[i] <= '0;
    end else begin
      state   <= nxt;
      begin_q <= {nxt == ST_S3, nxt == ST_S2, nxt == ST_S1};
      done_q  <= (nxt == ST_FIN);
      busy_q  <= !(nxt == ST_IDLE || nxt == ST_ERROR);
      if (start_ok) mask_q <= bus.run_mask;

      if (in_wait && nxt == ST_ERROR) begin
        error_q     <= 1'b1;
        err_layer_q <= cur_layer;
      end else if (start_ok) begin
        error_q     <= 1'b0;
        err_layer_q <= '0;
      end else if (bus.abort) begin
        error_q     <= 1'b0;
      end

      if (!bus.abort) begin
        if (in_start)     lat_q[cur_layer] <= '0;
        else if (in_wait) lat_q[cur_layer] <= lat_next;
      end
    end
  end

  assign bus.begin_conv1 = begin_q[0];
  assign bus.begin_conv2 = begin_q[1];
  assign bus.begin_fc    = begin_q[2];
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;
  assign bus.err_layer   = err_layer_q;
  assign bus.lat_conv1   = lat_q[LAYER_CONV1];
  assign bus.lat_conv2   = lat_q[LAYER_CONV2];
  assign bus.lat_fc      = lat_q[LAYER_FC];

endmodule
